// File: rtl/rst_ckpt.sv
// rst_ckpt: register status table with N_CDB clear ports, rs/rt lookup with CDB bypass, per-CDB regfile write enables and an N_CKPT circular snapshot buffer for save/release/restore
module rst_ckpt #(
  parameter int W_ADDR = 5,
  parameter int W_TAG  = 6,
  parameter int N_CDB  = 2,
  parameter int N_CKPT = 4,
  parameter int W_CKPT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [W_ADDR-1:0]            dispatch_rsaddr,
  input  logic [W_ADDR-1:0]            dispatch_rtaddr,
  output logic [W_TAG-1:0]             dispatch_rstag,
  output logic [W_TAG-1:0]             dispatch_rttag,
  output logic                         dispatch_rsvalid,
  output logic                         dispatch_rtvalid,
  input  logic [W_ADDR-1:0]            dispatch_addr,
  input  logic [W_TAG-1:0]             dispatch_tag,
  input  logic                         dispatch_valid,
  input  logic [N_CDB*W_TAG-1:0]       cdb_tag,
  input  logic [N_CDB-1:0]             cdb_valid,
  output logic [N_CDB*(2**W_ADDR)-1:0] regfile_wen_onehot,
  input  logic                         ckpt_save,
  output logic                         ckpt_save_ack,
  output logic [W_CKPT-1:0]            ckpt_id,
  input  logic                         ckpt_release,
  input  logic                         ckpt_restore,
  input  logic [W_CKPT-1:0]            ckpt_restore_id,
  output logic                         ckpt_full,
  output logic                         ckpt_empty,
  output logic                         ckpt_err
);
  localparam int N_ENTRY = 2**W_ADDR;
  typedef logic [W_TAG:0] ent_t;
  ent_t mem_r [N_ENTRY];
  ent_t mem_n [N_ENTRY];
  ent_t snap_r [N_CKPT][N_ENTRY];
  logic [W_CKPT-1:0] head_r, tail_r, head_n, tail_n, rdist;
  logic [W_CKPT:0] count_r, count_n;
  logic err_r, rst_ok, rel_ok, save_ok, err_n;
  ent_t rs_e, rt_e;
  function automatic ent_t clr(input ent_t e, input logic [N_CDB*W_TAG-1:0] t, input logic [N_CDB-1:0] v);
    logic h;
    h = 1'b0;
    for (int k = 0; k < N_CDB; k++) h = h | (v[k] && e[W_TAG] && e[W_TAG-1:0] == t[k*W_TAG +: W_TAG]);
    return h ? '0 : e;
  endfunction
  assign rs_e = clr(mem_r[dispatch_rsaddr], cdb_tag, cdb_valid);
  assign rt_e = clr(mem_r[dispatch_rtaddr], cdb_tag, cdb_valid);
  assign dispatch_rsvalid = rs_e[W_TAG];
  assign dispatch_rstag   = rs_e[W_TAG-1:0];
  assign dispatch_rtvalid = rt_e[W_TAG];
  assign dispatch_rttag   = rt_e[W_TAG-1:0];
  always_comb begin
    regfile_wen_onehot = '0;
    for (int k = 0; k < N_CDB; k++)
      for (int i = 0; i < N_ENTRY; i++)
        regfile_wen_onehot[k*N_ENTRY+i] = cdb_valid[k] && mem_r[i][W_TAG] && mem_r[i][W_TAG-1:0] == cdb_tag[k*W_TAG +: W_TAG];
  end
  assign ckpt_full     = count_r == (W_CKPT+1)'(N_CKPT);
  assign ckpt_empty    = count_r == '0;
  assign ckpt_save_ack = ckpt_save && !ckpt_full && !ckpt_restore;
  assign ckpt_id       = tail_r;
  assign ckpt_err      = err_r;
  assign save_ok       = ckpt_save_ack;
  assign rdist         = ckpt_restore_id - head_r;
  assign rst_ok        = ckpt_restore && ({1'b0, rdist} < count_r);
  // restoring the oldest slot frees everything, so a same-cycle release has nothing left to free
  assign rel_ok  = ckpt_release && !ckpt_empty && !(rst_ok && ckpt_restore_id == head_r);
  assign err_n   = (ckpt_restore && !rst_ok) || (ckpt_release && ckpt_empty);
  assign head_n  = head_r + W_CKPT'(rel_ok);
  assign tail_n  = rst_ok ? ckpt_restore_id : tail_r + W_CKPT'(save_ok);
  assign count_n = rst_ok ? {1'b0, W_CKPT'(ckpt_restore_id - head_n)}
                          : count_r + (W_CKPT+1)'(save_ok) - (W_CKPT+1)'(rel_ok);
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++)
      mem_n[i] = rst_ok ? clr(snap_r[ckpt_restore_id][i], cdb_tag, cdb_valid)
               : (dispatch_valid && dispatch_addr == W_ADDR'(i)) ? {1'b1, dispatch_tag}
               : clr(mem_r[i], cdb_tag, cdb_valid);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRY; i++) mem_r[i] <= '0;
      for (int s = 0; s < N_CKPT; s++)
        for (int i = 0; i < N_ENTRY; i++) snap_r[s][i] <= '0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      err_r   <= 1'b0;
    end else begin
      for (int i = 0; i < N_ENTRY; i++) mem_r[i] <= mem_n[i];
      // every slot, live or not, tracks CDB completions so a later restore never resurrects a finished producer
      for (int s = 0; s < N_CKPT; s++)
        for (int i = 0; i < N_ENTRY; i++)
          snap_r[s][i] <= (save_ok && tail_r == W_CKPT'(s)) ? mem_n[i] : clr(snap_r[s][i], cdb_tag, cdb_valid);
      head_r  <= head_n;
      tail_r  <= tail_n;
      count_r <= count_n;
      err_r   <= err_n;
    end
  end
endmodule

// File: tb/tb_rst_ckpt.sv
// tb_rst_ckpt: scoreboard bench for rst_ckpt covering lookup, CDB clear, checkpoint save/release/restore and error pulses
module tb_rst_ckpt;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] rsaddr, rtaddr, daddr;
  logic [5:0] rstag, rttag, dtag;
  logic rsvalid, rtvalid, dvalid;
  logic [11:0] cdb_tag;
  logic [1:0] cdb_valid;
  logic [63:0] wen;
  logic save, ack, release_i, restore, full, empty, err;
  logic [1:0] id, restore_id;
  typedef struct { string lbl; string sig; logic [63:0] v; } exp_t;
  exp_t q[$];
  exp_t e;
  logic [63:0] o;
  int n_chk = 0, n_pass = 0;
  rst_ckpt dut (
    .clk(clk), .reset(reset),
    .dispatch_rsaddr(rsaddr), .dispatch_rtaddr(rtaddr),
    .dispatch_rstag(rstag), .dispatch_rttag(rttag),
    .dispatch_rsvalid(rsvalid), .dispatch_rtvalid(rtvalid),
    .dispatch_addr(daddr), .dispatch_tag(dtag), .dispatch_valid(dvalid),
    .cdb_tag(cdb_tag), .cdb_valid(cdb_valid), .regfile_wen_onehot(wen),
    .ckpt_save(save), .ckpt_save_ack(ack), .ckpt_id(id),
    .ckpt_release(release_i), .ckpt_restore(restore), .ckpt_restore_id(restore_id),
    .ckpt_full(full), .ckpt_empty(empty), .ckpt_err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  function automatic exp_t mk(string l, string s, logic [63:0] v);
    exp_t x;
    x.lbl = l;
    x.sig = s;
    x.v = v;
    return x;
  endfunction
  function automatic logic [63:0] probe(string s);
    case (s)
      "rs":    return 64'({rsvalid, rstag});
      "rt":    return 64'({rtvalid, rttag});
      "wen":   return wen;
      "ack":   return 64'(ack);
      "id":    return 64'(id);
      "full":  return 64'(full);
      "empty": return 64'(empty);
      "err":   return 64'(err);
      default: return '1;
    endcase
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    dvalid = 0; daddr = 0; dtag = 0; cdb_valid = 0; cdb_tag = 0;
    save = 0; release_i = 0; restore = 0; restore_id = 0;
  endtask
  task automatic test_reset;
    idle(); rsaddr = 0; rtaddr = 0;
    repeat (2) tick();
    q.push_back(mk("reset rs", "rs", 0)); q.push_back(mk("reset rt", "rt", 0));
    q.push_back(mk("reset wen", "wen", 0)); q.push_back(mk("reset empty", "empty", 1));
    q.push_back(mk("reset full", "full", 0)); q.push_back(mk("reset ack", "ack", 0));
    q.push_back(mk("reset err", "err", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    reset = 0;
    tick();
  endtask
  task automatic test_cdb_clear;
    idle(); dvalid = 1; daddr = 3; dtag = 9; rsaddr = 3; #1;
    q.push_back(mk("no same-cycle dispatch bypass", "rs", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    idle(); #1;
    q.push_back(mk("r3 pending tag 9", "rs", 64'h49));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd9}; #1;
    q.push_back(mk("cdb bypass r3", "rs", 0)); q.push_back(mk("wen cdb0 r3", "wen", 64'h8));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    idle(); #1;
    q.push_back(mk("r3 cleared", "rs", 0)); q.push_back(mk("wen idle", "wen", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
  endtask
  task automatic test_dispatch_vs_cdb;
    idle(); dvalid = 1; daddr = 5; dtag = 4;
    tick();
    idle(); dvalid = 1; daddr = 5; dtag = 12; cdb_valid = 2'b10; cdb_tag = {6'd4, 6'd0}; rtaddr = 5; #1;
    q.push_back(mk("wen cdb1 r5", "wen", 64'h1 << 37)); q.push_back(mk("r5 bypassed", "rt", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    idle(); #1;
    q.push_back(mk("dispatch wins r5", "rt", 64'h4C));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
  endtask
  task automatic test_save_full;
    for (int i = 0; i < 5; i++) begin
      idle(); save = 1; #1;
      q.push_back(mk($sformatf("save%0d ack", i), "ack", (i < 4) ? 1 : 0));
      q.push_back(mk($sformatf("save%0d id", i), "id", (i < 4) ? i : 0));
      q.push_back(mk($sformatf("save%0d full", i), "full", (i == 4) ? 1 : 0));
      while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
      tick();
    end
    idle(); #1;
    q.push_back(mk("still full", "full", 1)); q.push_back(mk("not empty", "empty", 0));
    q.push_back(mk("tail unchanged", "id", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    for (int i = 0; i < 4; i++) begin
      idle(); release_i = 1;
      tick();
    end
    idle(); #1;
    q.push_back(mk("drained empty", "empty", 1)); q.push_back(mk("drained full", "full", 0));
    q.push_back(mk("legal release err", "err", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
  endtask
  task automatic test_restore;
    idle(); dvalid = 1; daddr = 1; dtag = 7;
    tick();
    idle(); save = 1; #1;
    q.push_back(mk("restore-save ack", "ack", 1)); q.push_back(mk("restore-save id", "id", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    idle(); dvalid = 1; daddr = 1; dtag = 20; rsaddr = 1;
    tick();
    idle(); #1;
    q.push_back(mk("r1 speculative 20", "rs", 64'h54));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    restore = 1; restore_id = 0; dvalid = 1; daddr = 6; dtag = 30;
    tick();
    idle(); rtaddr = 6; #1;
    q.push_back(mk("r1 restored 7", "rs", 64'h47)); q.push_back(mk("restore drops dispatch", "rt", 0));
    q.push_back(mk("restore empty", "empty", 1)); q.push_back(mk("restore err", "err", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
  endtask
  task automatic test_snap_cdb;
    idle(); dvalid = 1; daddr = 2; dtag = 8;
    tick();
    idle(); save = 1; #1;
    q.push_back(mk("snap save id", "id", 0)); q.push_back(mk("snap save ack", "ack", 1));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    idle(); cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd8}; dvalid = 1; daddr = 2; dtag = 40;
    tick();
    idle(); rsaddr = 2; #1;
    q.push_back(mk("r2 new tag 40", "rs", 64'h68));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    restore = 1; restore_id = 0; cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd7};
    tick();
    idle(); rtaddr = 1; #1;
    q.push_back(mk("snapshot cdb-cleared r2", "rs", 0)); q.push_back(mk("restore-cycle cdb r1", "rt", 0));
    q.push_back(mk("snap restore empty", "empty", 1));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
  endtask
  task automatic test_illegal;
    for (int i = 0; i < 2; i++) begin
      idle(); save = 1; #1;
      q.push_back(mk($sformatf("ill save%0d id", i), "id", i));
      while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
      tick();
    end
    idle(); restore = 1; restore_id = 2; #1;
    q.push_back(mk("err before edge", "err", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    idle(); rsaddr = 1; rtaddr = 5; #1;
    q.push_back(mk("illegal restore err", "err", 1)); q.push_back(mk("illegal restore tail", "id", 2));
    q.push_back(mk("illegal restore empty", "empty", 0)); q.push_back(mk("illegal restore r5", "rt", 64'h4C));
    q.push_back(mk("illegal restore r1", "rs", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    #1;
    q.push_back(mk("err one cycle", "err", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    for (int i = 0; i < 2; i++) begin
      idle(); release_i = 1;
      tick();
    end
    idle(); release_i = 1;
    tick();
    idle(); #1;
    q.push_back(mk("empty release err", "err", 1)); q.push_back(mk("empty release empty", "empty", 1));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    #1;
    q.push_back(mk("release err one cycle", "err", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
  endtask
  task automatic test_restore_release;
    for (int i = 0; i < 3; i++) begin
      idle(); save = 1; #1;
      q.push_back(mk($sformatf("rr save%0d id", i), "id", (2 + i) % 4));
      while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
      tick();
    end
    idle(); restore = 1; restore_id = 2; release_i = 1;
    tick();
    idle(); #1;
    q.push_back(mk("restore head+release empty", "empty", 1)); q.push_back(mk("restore head tail", "id", 2));
    q.push_back(mk("restore head+release err", "err", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    for (int i = 0; i < 2; i++) begin
      idle(); save = 1;
      tick();
    end
    idle(); restore = 1; restore_id = 3; release_i = 1;
    tick();
    idle(); #1;
    q.push_back(mk("restore younger+release empty", "empty", 1)); q.push_back(mk("restore younger tail", "id", 3));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    save = 1; #1;
    q.push_back(mk("post save ack", "ack", 1));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    idle(); restore = 1; restore_id = 3;
    tick();
    idle(); #1;
    q.push_back(mk("head advanced by release", "err", 0)); q.push_back(mk("final restore empty", "empty", 1));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
  endtask
  task automatic test_dual_cdb;
    idle(); dvalid = 1; daddr = 10; dtag = 50;
    tick();
    idle(); cdb_valid = 2'b11; cdb_tag = {6'd50, 6'd50}; rsaddr = 10; #1;
    q.push_back(mk("dual port wen", "wen", (64'h1 << 10) | (64'h1 << 42))); q.push_back(mk("dual bypass", "rs", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    idle(); #1;
    q.push_back(mk("dual cleared", "rs", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
  endtask
  task automatic test_async_reset;
    idle(); dvalid = 1; daddr = 4; dtag = 33;
    tick();
    idle(); save = 1; rsaddr = 4; #1;
    q.push_back(mk("r4 pending 33", "rs", 64'h61)); q.push_back(mk("pre-reset save id", "id", 3));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    idle(); #1;
    reset = 1; #1;
    q.push_back(mk("async reset rs", "rs", 0)); q.push_back(mk("async reset empty", "empty", 1));
    q.push_back(mk("async reset id", "id", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
    tick();
    reset = 0;
    tick();
    #1;
    q.push_back(mk("after reset rs", "rs", 0));
    while (q.size() > 0) begin e = q.pop_front(); o = probe(e.sig); n_chk++; if (o !== e.v) $display("FAIL %s: got %0h expected %0h", e.lbl, o, e.v); else n_pass++; end
  endtask
  initial begin
    test_reset();
    test_cdb_clear();
    test_dispatch_vs_cdb();
    test_save_full();
    test_restore();
    test_snap_cdb();
    test_illegal();
    test_restore_release();
    test_dual_cdb();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rst_ckpt.md
Name: rst_ckpt

Overview:
Register status table with checkpoint/restore, successor to the single-CDB RST. Tracks, per architectural register, the tag of the in-flight producer. Supports N_CDB parallel CDB clear ports and a circular buffer of N_CKPT branch snapshots for single-cycle mispredict recovery. Sits between dispatch, the CDBs and the register file, providing rs/rt tag lookup and per-CDB regfile write enables.

Parameters:
W_ADDR, 5, architectural register address width; N_ENTRY = 2**W_ADDR
W_TAG, 6, tag width; entry = {valid, tag}
N_CDB, 2, number of CDB clear ports
N_CKPT, 4, snapshot slots; power of two, >= 2
W_CKPT, 2, checkpoint id width = log2(N_CKPT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
dispatch_rsaddr / dispatch_rtaddr  in  W_ADDR  read addresses
dispatch_rstag / dispatch_rttag  out  W_TAG  producer tag
dispatch_rsvalid / dispatch_rtvalid  out  1  1 = value pending (tag meaningful)
dispatch_addr  in  W_ADDR  destination register
dispatch_tag  in  W_TAG  new producer tag
dispatch_valid  in  1  write enable
cdb_tag  in  N_CDB*W_TAG  port k at [k*W_TAG +: W_TAG]
cdb_valid  in  N_CDB  per-port valid
regfile_wen_onehot  out  N_CDB*N_ENTRY  port k one-hot at [k*N_ENTRY +: N_ENTRY]
ckpt_save  in  1  take snapshot
ckpt_save_ack  out  1  save accepted this cycle
ckpt_id  out  W_CKPT  id of slot granted (valid when ack)
ckpt_release  in  1  oldest branch resolved correct; free oldest slot
ckpt_restore  in  1  mispredict
ckpt_restore_id  in  W_CKPT  slot to restore
ckpt_full / ckpt_empty  out  1  buffer status
ckpt_err  out  1  registered one-cycle pulse: illegal restore/release

Behaviour:
- Main table mem_r[N_ENTRY]; snapshot array snap_r[N_CKPT][N_ENTRY]; head, tail (W_CKPT), count (W_CKPT+1).
- Reset (async): all table and snapshot entries 0, head = tail = count = 0, ckpt_err = 0. Outputs: reads 0, wen 0, ckpt_empty = 1, ckpt_full = 0, ack = 0.
- Lookup, combinational from mem_r. CDB bypass: if the entry is valid and its tag equals any valid cdb_tag this cycle, report rsvalid/rtvalid = 0 and tag = 0. Same-cycle dispatch write is not bypassed to reads.
- CAM per CDB port k: match = entry valid && tag == cdb_tag[k]. regfile_wen_onehot[k][i] = cdb_valid[k] && match(i). Tags are unique in the table, so at most one bit per port is set. Two ports carrying an equal tag both assert.
- Next state per entry: start from mem_r; clear to 0 on any CDB match; then a dispatch write to dispatch_addr overrides with {1, dispatch_tag}. Dispatch wins over a CDB clear on the same entry.
- CDB clears are also applied every cycle to every snapshot slot, live or not, using the same match rule on the snapshot contents.
- Save accepted when ckpt_save && !ckpt_full && !ckpt_restore:
  - snap[tail] <= main next-state (includes same-cycle dispatch and CDB effects);
  - ckpt_id = tail; tail++ (wraps); count++.
  - ckpt_save_ack is combinational.
  - A save while full or during a restore is dropped: ack = 0, no error.
- Release: head++ and count-- when count > 0. Release when empty is ignored and sets ckpt_err.
- Restore: legal when ckpt_restore_id is live, i.e. (ckpt_restore_id - head) mod N_CKPT < count.
  - Main table <= snap[id] with this cycle's CDB clears applied.
  - Same-cycle dispatch is dropped.
  - tail <= id; count <= (id - head') mod N_CKPT, where head' is head after any same-cycle release. This frees slot id and all younger slots.
  - Illegal restore: no state change, ckpt_err pulses.
- Restore + release same cycle: if ckpt_restore_id == head, the release is ignored and count becomes 0. Otherwise both take effect.
- ckpt_full = (count == N_CKPT); ckpt_empty = (count == 0).
- Pointers wrap mod N_CKPT. Count saturation is impossible because of the save and release gating.
- Reset mid-operation clears everything immediately, including any snapshot in flight.

Test Plan:
- Dispatch r3 <= tag 9, then next cycle CDB0 tag 9 -> rstag of r3 reads pending 9 after the first edge; during the CDB cycle rsvalid = 0 (bypass) and wen[0][3] = 1; after the edge the entry is 0.
- Same cycle: dispatch r5 <= tag 12 while CDB1 publishes r5's old tag 4 -> wen[1][5] = 1; r5 reads {1, 12} next cycle.
- Save 4 times with no release (N_CKPT = 4) -> ids 0,1,2,3 with ack = 1; ckpt_full = 1; 5th save gives ack = 0 and no state change.
- Set r1 = tag 7, save (id 0), dispatch r1 <= tag 20, then restore id 0 -> r1 reads {1, 7}; count = 0; ckpt_empty = 1.
- Snapshot holds r2 = tag 8; CDB0 publishes tag 8 one cycle before the restore -> after restore r2 reads invalid (0).
- Restore of id 2 while only ids 0 and 1 are live -> ckpt_err pulses one cycle; table and pointers unchanged. Release when empty -> ckpt_err pulses.
